// File: rtl/antirebote_multi_if.sv
`default_nettype none
// ============================================================================
//  Module   : antirebote_multi_if
//  Purpose  : Button inputs and debounced level/pulse outputs of antirebote_multi.
//  Revision : 1.0  initial release
// ============================================================================
interface antirebote_multi_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] entrada;
  logic [N_CH-1:0] estado;
  logic [N_CH-1:0] pulso_pres;
  logic [N_CH-1:0] pulso_suelta;
  logic [N_CH-1:0] pulso_largo;
  logic            cualquiera;

  modport master (
    output entrada,
    input  estado, pulso_pres, pulso_suelta, pulso_largo, cualquiera
  );

  modport slave (
    input  entrada,
    output estado, pulso_pres, pulso_suelta, pulso_largo, cualquiera
  );
endinterface
`default_nettype wire

// File: rtl/antirebote_multi.sv
`default_nettype none
// ============================================================================
//  Module   : antirebote_multi
//  Purpose  : N-channel button debouncer with press/release/long-press pulses.
//  Revision : 1.0  initial release
// ============================================================================
module antirebote_multi #(
  parameter int N_CH       = 4,
  parameter int STABLE_CNT = 16,
  parameter int LONG_CNT   = 1000
) (
  input  logic               clk,
  input  logic               reset,
  antirebote_multi_if.slave  bus
);

  localparam int                 c_cnt_w    = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STABLE_CNT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  logic [N_CH-1:0]    r_sync1;
  logic [N_CH-1:0]    r_sync2;
  logic [N_CH-1:0]    r_estado;
  logic [N_CH-1:0]    r_pres;
  logic [N_CH-1:0]    r_suelta;
  logic               r_cualquiera;
  logic [c_cnt_w-1:0] r_cnt [N_CH];

  logic [N_CH-1:0]    w_mismatch;
  logic [N_CH-1:0]    w_flip;
  logic [N_CH-1:0]    w_largo;

  // A channel flips on the STABLE_CNT-th consecutive mismatch.
  always_comb begin
    w_mismatch = r_sync2 ^ r_estado;
    w_flip     = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_flip[i] = w_mismatch[i] && (r_cnt[i] == c_cnt_last);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_estado     <= '0;
      r_pres       <= '0;
      r_suelta     <= '0;
      r_cualquiera <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1      <= bus.entrada;
      r_sync2      <= r_sync1;
      r_estado     <= r_estado ^ w_flip;
      r_pres       <= w_flip & r_sync2;
      r_suelta     <= w_flip & ~r_sync2;
      r_cualquiera <= |(w_flip & r_sync2);
      for (int i = 0; i < N_CH; i++) begin
        if (!w_mismatch[i] || w_flip[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + c_cnt_one;
        end
      end
    end
  end

  generate
    if (LONG_CNT > 0) begin : g_long
      localparam int                  c_hold_w   = $clog2(LONG_CNT + 1);
      localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(LONG_CNT);
      localparam logic [c_hold_w-1:0] c_hold_one = c_hold_w'(1);

      logic [c_hold_w-1:0] r_hold [N_CH];
      logic [N_CH-1:0]     r_largo;

      // Saturating counter: the pulse fires once per press, on reaching the limit.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_largo <= '0;
          for (int i = 0; i < N_CH; i++) begin
            r_hold[i] <= '0;
          end
        end else begin
          for (int i = 0; i < N_CH; i++) begin
            if (!r_estado[i]) begin
              r_hold[i]  <= '0;
              r_largo[i] <= 1'b0;
            end else if (r_hold[i] != c_hold_max) begin
              r_hold[i]  <= r_hold[i] + c_hold_one;
              r_largo[i] <= (r_hold[i] == (c_hold_max - c_hold_one));
            end else begin
              r_largo[i] <= 1'b0;
            end
          end
        end
      end

      assign w_largo = r_largo;
    end else begin : g_no_long
      assign w_largo = '0;
    end
  endgenerate

  assign bus.estado       = r_estado;
  assign bus.pulso_pres   = r_pres;
  assign bus.pulso_suelta = r_suelta;
  assign bus.pulso_largo  = w_largo;
  assign bus.cualquiera   = r_cualquiera;

  a_pres_suelta_excl: assert property (@(posedge clk) disable iff (reset)
    !(|(r_pres & r_suelta)));

endmodule
`default_nettype wire

// File: tb/tb_antirebote_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_antirebote_multi
//  Purpose  : Scoreboard bench for antirebote_multi (STABLE_CNT=4, LONG_CNT=10).
//  Revision : 1.0  initial release
// ============================================================================
module tb_antirebote_multi;

  localparam int NC  = 4;
  localparam int SC  = 4;
  localparam int LC  = 10;
  // Edges after the first sampling edge until the new level is visible.
  localparam int LAT = SC + 1;

  localparam int S_EST = 0, S_PRES = 1, S_SUEL = 2, S_LARGO = 3, S_ANY = 4;

  typedef struct {
    int         at;
    int         sel;
    logic [3:0] mask;
    logic [3:0] val;
    string      tag;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   edge_no = 0;
  int   total   = 0;
  int   bad     = 0;
  exp_t q[$];

  antirebote_multi_if #(.N_CH(NC)) bus ();

  antirebote_multi #(
    .N_CH       (NC),
    .STABLE_CNT (SC),
    .LONG_CNT   (LC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) edge_no <= edge_no + 1;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h edge=%0d", tag, got, exp, edge_no);
    end
  endtask

  function automatic logic [3:0] sig_val(int sel);
    case (sel)
      S_EST:   return bus.estado;
      S_PRES:  return bus.pulso_pres;
      S_SUEL:  return bus.pulso_suelta;
      S_LARGO: return bus.pulso_largo;
      default: return {3'b000, bus.cualquiera};
    endcase
  endfunction

  task automatic expect_at(int at, int sel, logic [3:0] mask, logic [3:0] val, string tag);
    exp_t e;
    int   idx;
    e.at = at; e.sel = sel; e.mask = mask; e.val = val; e.tag = tag;
    idx = q.size();
    for (int k = 0; k < q.size(); k++) begin
      if (q[k].at > at) begin
        idx = k;
        break;
      end
    end
    q.insert(idx, e);
  endtask

  task automatic expect_range(int from, int to, int sel, logic [3:0] mask, logic [3:0] val, string tag);
    for (int t = from; t <= to; t++) expect_at(t, sel, mask, val, tag);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= edge_no) begin
      exp_t e;
      e = q.pop_front();
      check_val(e.tag, 32'(sig_val(e.sel) & e.mask), 32'(e.val & e.mask));
    end
  end

  task automatic drive(logic [3:0] v, output int e1);
    @(negedge clk);
    bus.entrada = v;
    e1 = edge_no + 1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      check_val("drain", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    int e1, r1, p, rr;
    logic [3:0] pat [8];
    bus.entrada = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    expect_at(edge_no + 1, S_EST,   4'hf, 4'h0, "rst_estado");
    expect_at(edge_no + 1, S_PRES,  4'hf, 4'h0, "rst_pres");
    expect_at(edge_no + 1, S_SUEL,  4'hf, 4'h0, "rst_suelta");
    expect_at(edge_no + 1, S_LARGO, 4'hf, 4'h0, "rst_largo");
    expect_at(edge_no + 1, S_ANY,   4'h1, 4'h0, "rst_any");
    drain();
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Channel 0 press: latency, single pulse, long press, release
    drive(4'b0001, e1);
    p = e1 + LAT;
    expect_at(p - 1, S_EST,  4'h1, 4'h0, "t1_est_early");
    expect_at(p,     S_EST,  4'h1, 4'h1, "t1_est");
    expect_at(p,     S_PRES, 4'hf, 4'h1, "t1_pres");
    expect_at(p,     S_ANY,  4'h1, 4'h1, "t1_any");
    expect_at(p,     S_SUEL, 4'hf, 4'h0, "t1_no_suelta");
    expect_at(p + 1, S_PRES, 4'hf, 4'h0, "t1_pres_1cyc");
    expect_at(p + 1, S_ANY,  4'h1, 4'h0, "t1_any_1cyc");
    expect_at(p + 1, S_EST,  4'h1, 4'h1, "t1_est_hold");
    expect_range(p, p + LC - 1, S_LARGO, 4'h1, 4'h0, "t1_largo_early");
    expect_at(p + LC, S_LARGO, 4'hf, 4'h1, "t1_largo");
    expect_range(p + LC + 1, p + LC + 8, S_LARGO, 4'h1, 4'h0, "t1_largo_once");
    drain();
    drive(4'b0000, r1);
    expect_at(r1 + LAT - 1, S_EST,  4'h1, 4'h1, "t1_rel_early");
    expect_at(r1 + LAT,     S_EST,  4'h1, 4'h0, "t1_rel_est");
    expect_at(r1 + LAT,     S_SUEL, 4'hf, 4'h1, "t1_suelta");
    expect_at(r1 + LAT,     S_PRES, 4'hf, 4'h0, "t1_rel_nopres");
    expect_at(r1 + LAT + 1, S_SUEL, 4'hf, 4'h0, "t1_suelta_1cyc");
    drain();
    repeat (4) @(negedge clk);

    // Channel 1 bounce: 3 high, 1 low, 3 high, then low
    pat[0] = 4'b0010; pat[1] = 4'b0010; pat[2] = 4'b0010; pat[3] = 4'b0000;
    pat[4] = 4'b0010; pat[5] = 4'b0010; pat[6] = 4'b0010; pat[7] = 4'b0000;
    drive(pat[0], e1);
    expect_range(e1, e1 + 14, S_EST,  4'h2, 4'h0, "t2_est");
    expect_range(e1, e1 + 14, S_PRES, 4'h2, 4'h0, "t2_pres");
    expect_range(e1, e1 + 14, S_SUEL, 4'h2, 4'h0, "t2_suelta");
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      bus.entrada = pat[k];
    end
    drain();
    repeat (3) @(negedge clk);

    // Channel 2 press then release
    drive(4'b0100, e1);
    expect_at(e1 + LAT, S_PRES, 4'hf, 4'h4, "t3_pres");
    drain();
    repeat (2) @(negedge clk);
    drive(4'b0000, r1);
    expect_at(r1 + LAT - 1, S_SUEL, 4'h4, 4'h0, "t3_suelta_early");
    expect_at(r1 + LAT,     S_SUEL, 4'hf, 4'h4, "t3_suelta");
    expect_at(r1 + LAT,     S_PRES, 4'h4, 4'h0, "t3_nopres");
    expect_at(r1 + LAT + 1, S_SUEL, 4'h4, 4'h0, "t3_suelta_1cyc");
    drain();
    repeat (3) @(negedge clk);

    // Channel 3 held for 30 cycles, then pressed again
    drive(4'b1000, e1);
    p = e1 + LAT;
    expect_at(p, S_PRES, 4'h8, 4'h8, "t4_pres");
    expect_range(p, p + LC - 1, S_LARGO, 4'h8, 4'h0, "t4_largo_early");
    expect_at(p + LC, S_LARGO, 4'hf, 4'h8, "t4_largo");
    expect_range(p + LC + 1, e1 + 29, S_LARGO, 4'h8, 4'h0, "t4_largo_once");
    drain();
    drive(4'b0000, r1);
    expect_at(r1 + LAT, S_SUEL, 4'h8, 4'h8, "t4_suelta");
    expect_range(r1, r1 + LAT + 2, S_LARGO, 4'h8, 4'h0, "t4_rel_nolargo");
    drain();
    repeat (3) @(negedge clk);
    drive(4'b1000, e1);
    p = e1 + LAT;
    expect_at(p,          S_PRES,  4'h8, 4'h8, "t4_pres2");
    expect_at(p + LC - 1, S_LARGO, 4'h8, 4'h0, "t4_largo2_early");
    expect_at(p + LC,     S_LARGO, 4'h8, 4'h8, "t4_largo2");
    drain();
    drive(4'b0000, r1);
    expect_at(r1 + LAT, S_EST, 4'h8, 4'h0, "t4_rel2");
    drain();
    repeat (3) @(negedge clk);

    // All channels at once
    drive(4'b1111, e1);
    expect_at(e1 + LAT - 1, S_EST,  4'hf, 4'h0, "t5_est_early");
    expect_at(e1 + LAT,     S_EST,  4'hf, 4'hf, "t5_est");
    expect_at(e1 + LAT,     S_PRES, 4'hf, 4'hf, "t5_pres_all");
    expect_at(e1 + LAT,     S_ANY,  4'h1, 4'h1, "t5_any");
    drain();
    drive(4'b0000, r1);
    expect_at(r1 + LAT, S_SUEL, 4'hf, 4'hf, "t5_suelta_all");
    expect_at(r1 + LAT, S_PRES, 4'hf, 4'h0, "t5_rel_nopres");
    expect_at(r1 + LAT, S_ANY,  4'h1, 4'h0, "t5_rel_any");
    drain();
    repeat (4) @(negedge clk);

    // Reset while channel 0 is held high
    drive(4'b0001, e1);
    expect_at(e1 + LAT, S_EST, 4'h1, 4'h1, "t6_est");
    drain();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rr = edge_no + 1;
    expect_at(rr,     S_EST,  4'hf, 4'h0, "t6_est_rst");
    expect_at(rr,     S_SUEL, 4'hf, 4'h0, "t6_no_suelta");
    expect_at(rr,     S_PRES, 4'hf, 4'h0, "t6_no_pres");
    expect_at(rr + 1, S_SUEL, 4'hf, 4'h0, "t6_no_suelta_late");
    expect_at(rr + LAT,     S_EST,  4'h1, 4'h0, "t6_repress_early");
    expect_at(rr + 1 + LAT, S_EST,  4'h1, 4'h1, "t6_repress");
    expect_at(rr + 1 + LAT, S_PRES, 4'hf, 4'h1, "t6_repress_pulse");
    @(negedge clk);
    reset = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/antirebote_multi.md
ANTIREBOTE_MULTI -- requirements
Module: antirebote_multi

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning the number of independent button channels (N_CH >= 1).
REQ-002 The block SHALL have parameter STABLE_CNT, default 16, meaning the number of consecutive cycles a synchronized input must differ from the debounced level before that level changes (STABLE_CNT >= 1).
REQ-003 The block SHALL have parameter LONG_CNT, default 1000, meaning the number of cycles the debounced level must stay high before a long-press pulse is issued; 0 disables long-press.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 entrada  input  N_CH  raw asynchronous button inputs, one bit per channel.
REQ-007 estado  output  N_CH  registered debounced level per channel.
REQ-008 pulso_pres  output  N_CH  one-cycle pulse per channel on a debounced 0->1 transition.
REQ-009 pulso_suelta  output  N_CH  one-cycle pulse per channel on a debounced 1->0 transition (button release).
REQ-010 pulso_largo  output  N_CH  one-cycle pulse per channel when a press has lasted LONG_CNT cycles.
REQ-011 cualquiera  output  1  registered OR of all pulso_pres bits, asserted in the same cycle as them.

Function
REQ-012 Each channel SHALL pass entrada[i] through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-013 Each channel SHALL hold a stability counter of width clog2(STABLE_CNT) bits, minimum 1 bit.
REQ-014 Counter rule per edge: if sync2 == estado, the counter SHALL clear to 0.
REQ-015 Counter rule per edge: if sync2 != estado and counter < STABLE_CNT-1, the counter SHALL increment by 1.
REQ-016 Counter rule per edge: if sync2 != estado and counter == STABLE_CNT-1, estado SHALL take sync2 and the counter SHALL clear to 0.
REQ-017 Latency: if entrada[i] changes and then holds, estado[i] SHALL change on the (STABLE_CNT+2)-th rising edge, counting the first edge that samples the new value as edge 1.
REQ-018 A mismatch lasting fewer than STABLE_CNT cycles after synchronization SHALL leave estado unchanged and SHALL restart the count from 0 on the next mismatch.
REQ-019 pulso_pres[i] and pulso_suelta[i] SHALL be registered, asserted for exactly one cycle, and asserted in the same cycle that estado[i] shows its new value.
REQ-020 pulso_pres[i] and pulso_suelta[i] SHALL never be asserted in the same cycle.
REQ-021 Each channel SHALL hold a hold counter that clears while estado[i] = 0, increments while estado[i] = 1, and saturates at LONG_CNT without wrapping.
REQ-022 pulso_largo[i] SHALL assert for one cycle on the edge the hold counter reaches LONG_CNT; it SHALL then stay 0 until estado[i] returns to 0 and rises again.
REQ-023 If LONG_CNT = 0, pulso_largo SHALL be tied to 0 and no hold counter logic SHALL be generated.
REQ-024 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-025 While reset is high at a rising edge, sync1, sync2, estado, both counters and all pulse outputs SHALL become 0 on that edge, overriding all other updates.
REQ-026 Reset asserted mid-count or mid-press SHALL discard the count and SHALL NOT emit pulso_suelta for the forced 1->0 change of estado.
REQ-027 After reset deasserts with entrada held high, the channel SHALL debounce from estado = 0 under REQ-017 and emit pulso_pres.

Verification
REQ-028 STABLE_CNT=4, entrada[0] 0->1 held -> estado[0]=1 and pulso_pres[0]=1 on edge 6 for one cycle; cualquiera=1 on the same edge.
REQ-029 STABLE_CNT=4, entrada[1] high for 3 cycles, low 1, high 3, then low -> estado[1] stays 0, no pulses.
REQ-030 STABLE_CNT=4, press then release entrada[2] -> pulso_suelta[2]=1 for one cycle, 6 edges after the release.
REQ-031 LONG_CNT=10, hold entrada[3] high for 30 cycles -> exactly one pulso_largo[3], 10 cycles after pulso_pres[3]; a second press gives a second pulso_largo.
REQ-032 All channels pressed on the same edge -> pulso_pres = all ones in one cycle and cualquiera = 1.
REQ-033 reset pulsed while estado[0]=1 -> estado=0 next edge, no pulso_suelta, re-press after REQ-017 latency.
